echo_detector: RTL

- Sits between receive_beamformer and time_of_flight.
- Consumes the aggregated receive waveform, rectifies it about a DC midpoint, and smooths it with an exponential envelope follower.
- Ignores transmitter ring-down with a blanking window, then confirms an echo with a threshold, a consecutive-sample count and hysteresis.
- Reports first-echo time, peak envelope and peak time once per listen window.

---
 rtl/echo_pkg.sv | 21 ++
 rtl/envelope_follower.sv | 49 ++++
 rtl/echo_detector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared types, default widths and helpers for the echo detection chain.
package echo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIME_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    ARMED,
    CONFIRM,
    DETECTED,
    DONE
  } echo_state_t;

  // Subtraction clamped at zero, used for the hysteresis release level.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/envelope_follower.sv
// Rectifies samples about a DC midpoint and smooths them with a
// shift-based exponential moving average; env is registered.
module envelope_follower #(
  parameter int DATA_WIDTH = 16,
  parameter int DC_OFFSET  = 1024,
  parameter int AVG_SHIFT  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] env
);

  localparam int W = DATA_WIDTH + 1;
  localparam logic signed [W-1:0] DC_MID = W'(DC_OFFSET);

  logic signed [W-1:0]   centered;
  logic signed [W-1:0]   delta;
  logic signed [W-1:0]   step;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] env_reg;
  logic [DATA_WIDTH-1:0] env_next;

  always_comb begin
    centered = $signed({1'b0, sample}) - DC_MID;
    mag      = centered[W-1] ? (~centered[DATA_WIDTH-1:0] + 1'b1)
                             : centered[DATA_WIDTH-1:0];
    delta    = $signed({1'b0, mag}) - $signed({1'b0, env_reg});
    // Arithmetic shift floors toward -inf, so a falling envelope never
    // undershoots the magnitude and a rising one never overshoots it.
    step     = delta >>> AVG_SHIFT;
    env_next = DATA_WIDTH'({1'b0, env_reg} + step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_reg <= '0;
    end else if (clear) begin
      env_reg <= '0;
    end else if (sample_valid) begin
      env_reg <= env_next;
    end
  end

  assign env = env_reg;

endmodule

// File: rtl/echo_detector.sv
// Echo detector: envelope, ring-down blanking, confirm/hysteresis FSM and
// once-per-window reporting of first-echo time and envelope peak.
module echo_detector
  import echo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int TIME_WIDTH      = DEF_TIME_WIDTH,
  parameter int DC_OFFSET       = 1024,
  parameter int AVG_SHIFT       = 3,
  parameter int BLANK_CYCLES    = 1048576,
  parameter int LISTEN_CYCLES   = 16000000,
  parameter int CONFIRM_SAMPLES = 4,
  parameter int HYST            = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  burst_start_in,
  input  logic [TIME_WIDTH-1:0] time_since_emission_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic [DATA_WIDTH-1:0] threshold_in,
  output logic [DATA_WIDTH-1:0] envelope_out,
  output logic                  echo_detected_out,
  output logic [TIME_WIDTH-1:0] echo_time_out,
  output logic [DATA_WIDTH-1:0] peak_out,
  output logic [TIME_WIDTH-1:0] peak_time_out,
  output logic                  valid_out
);

  localparam int CW = $clog2(CONFIRM_SAMPLES + 1);
  localparam logic [CW-1:0]         CONFIRM_N = CW'(CONFIRM_SAMPLES);
  localparam logic [TIME_WIDTH-1:0] BLANK_T   = TIME_WIDTH'(BLANK_CYCLES);
  localparam logic [TIME_WIDTH-1:0] LISTEN_T  = TIME_WIDTH'(LISTEN_CYCLES);

  echo_state_t           state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next, count_inc;
  logic [DATA_WIDTH-1:0] env;
  logic [DATA_WIDTH-1:0] rel_level;
  logic [DATA_WIDTH-1:0] peak_reg, peak_next;
  logic [TIME_WIDTH-1:0] evt_time_reg;
  logic [TIME_WIDTH-1:0] echo_time_reg, echo_time_next;
  logic [TIME_WIDTH-1:0] peak_time_reg, peak_time_next;
  logic                  env_evt_reg;
  logic                  detected_reg, detected_next;
  logic                  valid_reg, valid_next;
  logic                  hit, below_rel, timed_out, blank_over;

  envelope_follower #(
    .DATA_WIDTH (DATA_WIDTH),
    .DC_OFFSET  (DC_OFFSET),
    .AVG_SHIFT  (AVG_SHIFT)
  ) u_env (
    .clk          (clk_in),
    .rst_n        (rst_in),
    .clear        (burst_start_in),
    .sample_valid (sample_valid_in),
    .sample       (sample_in),
    .env          (env)
  );

  // env settles one cycle after its sample; remember that a fresh value is
  // pending and which emission time it belongs to.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      env_evt_reg  <= 1'b0;
      evt_time_reg <= '0;
    end else begin
      env_evt_reg <= sample_valid_in && !burst_start_in;
      if (sample_valid_in) begin
        evt_time_reg <= time_since_emission_in;
      end
    end
  end

  always_comb begin
    rel_level  = DATA_WIDTH'(sat_sub(32'(threshold_in), 32'(HYST)));
    hit        = env >= threshold_in;
    below_rel  = env < rel_level;
    timed_out  = time_since_emission_in >= LISTEN_T;
    blank_over = time_since_emission_in >= BLANK_T;
    count_inc  = count_reg + 1'b1;
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    detected_next  = detected_reg;
    echo_time_next = echo_time_reg;
    peak_next      = peak_reg;
    peak_time_next = peak_time_reg;

    if (burst_start_in) begin
      state_next     = BLANK;
      count_next     = '0;
      detected_next  = 1'b0;
      echo_time_next = '0;
      peak_next      = '0;
      peak_time_next = '0;
    end else begin
      case (state_reg)
        IDLE: ;
        BLANK: begin
          if (blank_over) state_next = ARMED;
        end
        ARMED: begin
          if (timed_out) begin
            state_next = DONE;
          end else if (env_evt_reg && hit) begin
            echo_time_next = evt_time_reg;
            count_next     = CW'(1);
            if (CONFIRM_SAMPLES <= 1) begin
              state_next     = DETECTED;
              detected_next  = 1'b1;
              peak_next      = env;
              peak_time_next = evt_time_reg;
            end else begin
              state_next = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (timed_out) begin
            state_next = DONE;
            count_next = '0;
          end else if (env_evt_reg) begin
            if (hit) begin
              count_next = count_inc;
              if (count_inc == CONFIRM_N) begin
                state_next     = DETECTED;
                detected_next  = 1'b1;
                peak_next      = env;
                peak_time_next = evt_time_reg;
              end
            end else begin
              count_next = '0;
              state_next = ARMED;
            end
          end
        end
        DETECTED: begin
          // Strict compare keeps the earliest time on a tied peak.
          if (env_evt_reg && (env > peak_reg)) begin
            peak_next      = env;
            peak_time_next = evt_time_reg;
          end
          if (timed_out || (env_evt_reg && below_rel)) begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // DONE always exits after one cycle, so this marks entry only.
    valid_next = (state_next == DONE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      detected_reg  <= 1'b0;
      echo_time_reg <= '0;
      peak_reg      <= '0;
      peak_time_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      detected_reg  <= detected_next;
      echo_time_reg <= echo_time_next;
      peak_reg      <= peak_next;
      peak_time_reg <= peak_time_next;
      valid_reg     <= valid_next;
    end
  end

  assign envelope_out      = env;
  assign echo_detected_out = detected_reg;
  assign echo_time_out     = echo_time_reg;
  assign peak_out          = peak_reg;
  assign peak_time_out     = peak_time_reg;
  assign valid_out         = valid_reg;

endmodule
